// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch constants (instruction width, NOP encoding) and the RUN/HALT state type
package fetch_unit_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_unit_pc_gen.sv
// fetch_unit_pc_gen: next-PC select (hold / +4 / redirect target) with redirect alignment check
module fetch_unit_pc_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic                  stall_i,
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic                  misaligned_o
);
  assign misaligned_o = redirect_i && (target_i[1:0] != 2'b00);
  always_comb
    next_pc_o = halt_i     ? pc_i :
                redirect_i ? (misaligned_o ? pc_i : target_i) :
                stall_i    ? pc_i : pc_i + ADDR_WIDTH'(4);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner driving the instruction ROM, IF/ID register with valid/ready, redirect and misalignment halt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [DATA_WIDTH-1:0]  imem_data_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_target_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   halted_o,
  output logic [ADDR_WIDTH-1:0]  fault_addr_o,
  output logic [COUNT_WIDTH-1:0] fetch_count_o
);
  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, pc_out_q, pc_out_d, fault_q, fault_d;
  logic [DATA_WIDTH-1:0]  instr_q, instr_d;
  logic                   valid_q, valid_d, stall, halt, misaligned;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  assign halt  = state_q == HALT;
  assign stall = valid_q && !ready_i;
  fetch_unit_pc_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_gen (
    .pc_i        (pc_q),
    .halt_i      (halt),
    .redirect_i  (redirect_i),
    .target_i    (redirect_target_i),
    .stall_i     (stall),
    .next_pc_o   (pc_d),
    .misaligned_o(misaligned)
  );
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    fault_d  = fault_q;
    count_d  = count_q + COUNT_WIDTH'(valid_q && ready_i);
    if (!halt && redirect_i) begin
      valid_d = 1'b0;
      instr_d = DATA_WIDTH'(NOP_INSTR);
      state_d = misaligned ? HALT : RUN;
      fault_d = misaligned ? redirect_target_i : fault_q;
    end else if (!halt && !stall) begin
      valid_d  = 1'b1;
      instr_d  = imem_data_i;
      pc_out_d = pc_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= DATA_WIDTH'(NOP_INSTR);
      pc_out_q <= '0;
      fault_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end
  assign imem_addr_o   = pc_q;
  assign valid_o       = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign halted_o      = halt;
  assign fault_addr_o  = fault_q;
  assign fetch_count_o = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (streaming, stall, redirect, halt, PC wrap)
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst = 1'b1, redirect = 1'b0, ready = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] addr_a, data_a, instr_a, pc_a, fault_a, count_a;
  logic [31:0] addr_b, data_b, instr_b, pc_b, fault_b, count_b;
  logic        valid_a, halted_a, valid_b, halted_b;
  int cmp = 0, bad = 0;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      default: return {a[15:0] ^ 16'h5a5a, a[15:0]};
    endcase
  endfunction
  assign data_a = rom_word(addr_a);
  assign data_b = rom_word(addr_b);
  fetch_unit dut_a (
    .clk_i(clk), .rst_i(rst), .imem_addr_o(addr_a), .imem_data_i(data_a),
    .redirect_i(redirect), .redirect_target_i(target), .ready_i(ready),
    .valid_o(valid_a), .instr_o(instr_a), .pc_o(pc_a), .halted_o(halted_a),
    .fault_addr_o(fault_a), .fetch_count_o(count_a)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk_i(clk), .rst_i(rst), .imem_addr_o(addr_b), .imem_data_i(data_b),
    .redirect_i(redirect), .redirect_target_i(target), .ready_i(ready),
    .valid_o(valid_b), .instr_o(instr_b), .pc_o(pc_b), .halted_o(halted_b),
    .fault_addr_o(fault_b), .fetch_count_o(count_b)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; ready = 1'b0; target = '0;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask
  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; redirect = 1'b0;
    tick(); tick();
    cmp++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", valid_a); end
    cmp++; if (instr_a !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", instr_a, NOP); end
    cmp++; if (pc_a !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_a); end
    cmp++; if (addr_a !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr_a); end
    cmp++; if (halted_a !== 1'b0) begin bad++; $display("FAIL rst_halted got=%h exp=0", halted_a); end
    cmp++; if (fault_a !== 32'h0) begin bad++; $display("FAIL rst_fault got=%h exp=0", fault_a); end
    cmp++; if (count_a !== 32'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", count_a); end
    cmp++; if (addr_b !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_addr_b got=%h exp=fffffff8", addr_b); end
    rst = 1'b0;
  endtask
  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 5; i++) sb.push_back('{32'(i * 4), rom_word(32'(i * 4))});
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp++; if (valid_a !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%h exp=1", i, valid_a); end
      e = sb.pop_front();
      cmp++; if (pc_a !== e.pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, pc_a, e.pc); end
      cmp++; if (instr_a !== e.instr) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instr_a, e.instr); end
    end
    cmp++; if (count_a !== 32'd4) begin bad++; $display("FAIL stream_count got=%0d exp=4", count_a); end
  endtask
  task automatic test_stall();
    do_reset();
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h8) begin bad++; $display("FAIL stall_pc[%0d] got=%h/%h exp=1/8", i, valid_a, pc_a); end
      cmp++; if (instr_a !== rom_word(32'h8)) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, instr_a, rom_word(32'h8)); end
      cmp++; if (addr_a !== 32'hC) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=c", i, addr_a); end
      cmp++; if (count_a !== 32'd2) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=2", i, count_a); end
    end
    ready = 1'b1;
    tick();
    cmp++; if (pc_a !== 32'hC) begin bad++; $display("FAIL stall_release_pc got=%h exp=c", pc_a); end
    cmp++; if (count_a !== 32'd3) begin bad++; $display("FAIL stall_release_count got=%0d exp=3", count_a); end
  endtask
  task automatic test_redirect();
    do_reset();
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    tick();
    redirect = 1'b1; target = 32'h100;
    tick();
    redirect = 1'b0;
    cmp++; if (valid_a !== 1'b0) begin bad++; $display("FAIL redir_bubble_valid got=%h exp=0", valid_a); end
    cmp++; if (instr_a !== NOP) begin bad++; $display("FAIL redir_bubble_instr got=%h exp=%h", instr_a, NOP); end
    cmp++; if (addr_a !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=100", addr_a); end
    ready = 1'b1;
    tick();
    cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h100) begin bad++; $display("FAIL redir_target got=%h/%h exp=1/100", valid_a, pc_a); end
    cmp++; if (instr_a !== rom_word(32'h100)) begin bad++; $display("FAIL redir_instr got=%h exp=%h", instr_a, rom_word(32'h100)); end
    cmp++; if (count_a !== 32'd2) begin bad++; $display("FAIL redir_killed_count got=%0d exp=2", count_a); end
    tick();
    cmp++; if (pc_a !== 32'h104 || count_a !== 32'd3) begin bad++; $display("FAIL redir_next got=%h/%0d exp=104/3", pc_a, count_a); end
  endtask
  task automatic test_redirect_accept();
    do_reset();
    ready = 1'b1;
    repeat (2) tick();
    cmp++; if (pc_a !== 32'h4 || count_a !== 32'd1) begin bad++; $display("FAIL racc_pre got=%h/%0d exp=4/1", pc_a, count_a); end
    redirect = 1'b1; target = 32'h40;
    tick();
    redirect = 1'b0;
    cmp++; if (count_a !== 32'd2) begin bad++; $display("FAIL racc_count got=%0d exp=2", count_a); end
    cmp++; if (valid_a !== 1'b0) begin bad++; $display("FAIL racc_bubble got=%h exp=0", valid_a); end
    tick();
    cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h40) begin bad++; $display("FAIL racc_target got=%h/%h exp=1/40", valid_a, pc_a); end
  endtask
  task automatic test_halt();
    do_reset();
    ready = 1'b1;
    tick();
    redirect = 1'b1; target = 32'h102;
    tick();
    cmp++; if (halted_a !== 1'b1) begin bad++; $display("FAIL halt_flag got=%h exp=1", halted_a); end
    cmp++; if (fault_a !== 32'h102) begin bad++; $display("FAIL halt_fault got=%h exp=102", fault_a); end
    cmp++; if (valid_a !== 1'b0 || instr_a !== NOP) begin bad++; $display("FAIL halt_out got=%h/%h exp=0/%h", valid_a, instr_a, NOP); end
    cmp++; if (addr_a !== 32'h4) begin bad++; $display("FAIL halt_addr got=%h exp=4", addr_a); end
    target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++; if (halted_a !== 1'b1 || valid_a !== 1'b0 || addr_a !== 32'h4 || fault_a !== 32'h102) begin
        bad++; $display("FAIL halt_hold[%0d] got=%h/%h/%h/%h exp=1/0/4/102", i, halted_a, valid_a, addr_a, fault_a);
      end
      cmp++; if (count_a !== 32'd1) begin bad++; $display("FAIL halt_count[%0d] got=%0d exp=1", i, count_a); end
    end
    redirect = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp++; if (halted_a !== 1'b0 || addr_a !== 32'h0 || count_a !== 32'd0 || fault_a !== 32'h0) begin
      bad++; $display("FAIL halt_reset got=%h/%h/%0d/%h exp=0/0/0/0", halted_a, addr_a, count_a, fault_a);
    end
    tick();
    cmp++; if (valid_a !== 1'b1 || pc_a !== 32'h0) begin bad++; $display("FAIL halt_restart got=%h/%h exp=1/0", valid_a, pc_a); end
  endtask
  task automatic test_wrap();
    do_reset();
    sb.push_back('{32'hFFFF_FFF8, rom_word(32'hFFFF_FFF8)});
    sb.push_back('{32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)});
    sb.push_back('{32'h0000_0000, rom_word(32'h0)});
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      cmp++; if (valid_b !== 1'b1 || pc_b !== e.pc) begin bad++; $display("FAIL wrap_pc[%0d] got=%h/%h exp=1/%h", i, valid_b, pc_b, e.pc); end
      cmp++; if (instr_b !== e.instr) begin bad++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", i, instr_b, e.instr); end
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_accept();
    test_halt();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
